// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// State encoding and default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit combinational full subtractor.
// Shared cell that the controller steps LSB first.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - Bin controller.
// Runs one full_sub_cell over WIDTH cycles, LSB first.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Dif,
  output logic             Bout,
  output logic             ovf
);

  state_t state, state_n;

  logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
  logic [CNT_W-1:0] cnt;
  logic             brw, a_msb, b_msb;
  logic             d, bo, last;

  full_sub_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  assign res_n = {d, res[WIDTH-1:1]};
  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Dif   <= '0;
      Bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_sh  <= a;
        b_sh  <= b;
        brw   <= Bin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        res  <= res_n;
        brw  <= bo;
        cnt  <= cnt + CNT_W'(1);
        // results only move on entry to DONE
        if (last) begin
          Dif  <= res_n;
          Bout <= bo;
          ovf  <= (a_msb != b_msb) && (res_n[WIDTH-1] != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl.
// Directed table, corner sequences, random and WIDTH=2 sweep.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] dif8;

  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2, ovf2;
  logic [1:0] dif2;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .Bin(bin8),
    .busy(busy8), .done(done8),
    .Dif(dif8), .Bout(bout8), .ovf(ovf8)
  );

  serial_sub_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .Bin(bin2),
    .busy(busy2), .done(done2),
    .Dif(dif2), .Bout(bout2), .ovf(ovf2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference: plain integer arithmetic, overflow from operand/result signs
  function automatic void model(input int w, input int a, input int b,
                                input int bin, output int dif,
                                output int bout, output int ov);
    int mask, sa, sb, sd;
    mask = (1 << w) - 1;
    dif  = (a - b - bin) & mask;
    bout = (a < b + bin) ? 1 : 0;
    sa   = (a >> (w - 1)) & 1;
    sb   = (b >> (w - 1)) & 1;
    sd   = (dif >> (w - 1)) & 1;
    ov   = (sa != sb && sd != sa) ? 1 : 0;
  endfunction

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic ci, output int lat);
    @(negedge clk);
    a8 = ai; b8 = bi; bin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = $urandom; b8 = $urandom; bin8 = 1'($urandom);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [1:0] ai, input logic [1:0] bi,
                     input logic ci, output int lat);
    @(negedge clk);
    a2 = ai; b2 = bi; bin2 = ci; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] dif;
    logic       bout, ovf;
  } vec_t;

  vec_t vt[7];

  initial begin
    int lat, ed, eb, eo, nd, prev, cyc;
    logic [7:0] ra, rb;
    logic rc;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vt[6] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset dif", dif8, 0);
    chk("reset bout", bout8, 0);
    chk("reset ovf", ovf8, 0);

    foreach (vt[i]) begin
      op8(vt[i].a, vt[i].b, vt[i].bin, lat);
      chk($sformatf("vec%0d latency", i), lat, 8);
      chk($sformatf("vec%0d busy", i), busy8, 1);
      chk($sformatf("vec%0d dif", i), dif8, vt[i].dif);
      chk($sformatf("vec%0d bout", i), bout8, vt[i].bout);
      chk($sformatf("vec%0d ovf", i), ovf8, vt[i].ovf);
      @(negedge clk);
      chk($sformatf("vec%0d done drop", i), done8, 0);
      chk($sformatf("vec%0d busy drop", i), busy8, 0);
      chk($sformatf("vec%0d hold", i), dif8, vt[i].dif);
    end

    // start pulses during RUN and DONE must be dropped
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'hFF; b8 = 8'h00;
    nd = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done8) nd++;
      start8 = (k == 3) || done8;
    end
    start8 = 1'b0;
    chk("busy-start done count", nd, 1);
    chk("busy-start dif", dif8, 8'h0F);
    chk("busy-start busy", busy8, 0);

    // reset on the 4th RUN edge
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy8, 0);
    chk("midrst done", done8, 0);
    chk("midrst dif", dif8, 0);
    chk("midrst bout", bout8, 0);
    chk("midrst ovf", ovf8, 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("midrst no done", nd, 0);
    op8(8'h5A, 8'h3C, 1'b0, lat);
    chk("post-rst latency", lat, 8);
    chk("post-rst dif", dif8, 8'h1E);

    // held start: back-to-back, 10-cycle spacing
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
    nd = 0; prev = -1;
    for (cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      if (done8) begin
        nd++;
        chk("b2b dif", dif8, 8'hFE);
        chk("b2b bout", bout8, 1);
        chk("b2b ovf", ovf8, 0);
        if (prev >= 0) chk("b2b spacing", cyc - prev, 10);
        prev = cyc;
      end
    end
    start8 = 1'b0;
    chk("b2b pulses", nd, 3);
    lat = 0;
    while (busy8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b idle", busy8, 0);

    // random operands against the arithmetic model
    repeat (40) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, lat);
      model(8, int'(ra), int'(rb), int'(rc), ed, eb, eo);
      chk("rand latency", lat, 8);
      chk($sformatf("rand %h-%h-%0d dif", ra, rb, rc), dif8, ed);
      chk($sformatf("rand %h-%h-%0d bout", ra, rb, rc), bout8, eb);
      chk($sformatf("rand %h-%h-%0d ovf", ra, rb, rc), ovf8, eo);
      @(negedge clk);
    end

    // exhaustive sweep on the WIDTH=2 build
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          op2(2'(x), 2'(y), 1'(c), lat);
          model(2, x, y, c, ed, eb, eo);
          chk("w2 latency", lat, 2);
          chk($sformatf("w2 %0d-%0d-%0d dif", x, y, c), dif2, ed);
          chk($sformatf("w2 %0d-%0d-%0d bout", x, y, c), bout2, eb);
          chk($sformatf("w2 %0d-%0d-%0d ovf", x, y, c), ovf2, eo);
          @(negedge clk);
        end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
